video_sync_timer: RTL and testbench

- Parametrised horizontal plus vertical video timing generator. It replaces separate hsync/vsync modules with a single block.
- Produces the pixel-rate enable, hsync/vsync with selectable polarity, x/y position, the active-video flag, and line-end/frame-end strobes.
- Timing values are runtime ports, shadowed at frame boundaries so a mode switch never tears a frame.
- Sits between the system clock and the pixel/colour generator and pong logic.

---
 rtl/video_sync_timer_pkg.sv | 49 ++++
 rtl/video_sync_timer_axis.sv | 87 ++++++++
 rtl/video_sync_timer.sv | 155 +++++++++++++++
 tb/tb_video_sync_timer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/video_sync_timer_pkg.sv
// -----------------------------------------------------------------------------
// video_sync_timer_pkg
// Shared definitions for the video timing generator:
//   - 640x480@60 reference segment lengths (pixels / lines)
//   - sync polarity constants
//   - sync_level(): maps "inside sync pulse" plus polarity to the pin level
// No ports (package).
// -----------------------------------------------------------------------------
package video_sync_timer_pkg;

    // 640x480@60 horizontal segments, in pixels
    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FRONT  = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BACK   = 48;

    // 640x480@60 vertical segments, in lines
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FRONT  = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BACK   = 33;

    // Sync polarity encodings
    localparam logic SYNC_POS = 1'b1;
    localparam logic SYNC_NEG = 1'b0;

    // Segment lengths of one axis, wide enough for any supported mode
    typedef struct packed {
        logic [15:0] active;
        logic [15:0] front;
        logic [15:0] sync;
        logic [15:0] back;
    } axis_timing_t;

    localparam axis_timing_t VGA640_H = '{16'd640, 16'd16, 16'd96, 16'd48};
    localparam axis_timing_t VGA640_V = '{16'd480, 16'd10, 16'd2, 16'd33};

    // Pin level for a sync output: asserted level equals the polarity bit
    function automatic logic sync_level(input logic in_pulse, input logic pol);
        logic level;
        if (in_pulse) begin
            level = pol;
        end else begin
            level = ~pol;
        end
        return level;
    endfunction

endpackage

// File: rtl/video_sync_timer_axis.sv
// -----------------------------------------------------------------------------
// sync_axis_counter
// One timing axis (horizontal or vertical): position counter over
// Active+Front+Sync+Back, wrap strobe, registered sync and in-active flags,
// and a configuration-legality flag.
// Ports:
//   CLK, RESET        clock, synchronous active-high clear (also used as hold)
//   Advance           step the position this cycle
//   Active/Front/Sync/Back  segment lengths (shadowed by the parent)
//   Pol               sync polarity to apply from the next cycle on
//   Count             current position
//   Wrap              Advance at the last position (combinational)
//   SyncOut, InActive registered from the next position, aligned with Count
//   Error             segment set is illegal (combinational from inputs)
// -----------------------------------------------------------------------------
module sync_axis_counter
    import video_sync_timer_pkg::*;
#(
    parameter int W = 10
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         Advance,
    input  logic [W-1:0] Active,
    input  logic [W-1:0] Front,
    input  logic [W-1:0] Sync,
    input  logic [W-1:0] Back,
    input  logic         Pol,
    output logic [W-1:0] Count,
    output logic         Wrap,
    output logic         SyncOut,
    output logic         InActive,
    output logic         Error
);

    // A total of exactly 2^W still fits a W-bit position counter
    localparam logic [W+1:0] LIMIT = (W+2)'(1) << W;

    logic [W-1:0] count_q, count_d;
    logic         sync_q, sync_d;
    logic         act_q, act_d;
    logic [W+1:0] sync_lo_s, sync_hi_s, total_s, count_ext_s, next_ext_s;

    // Segment boundaries, wrap detection and legality
    always_comb begin
        sync_lo_s   = {2'b00, Active} + {2'b00, Front};
        sync_hi_s   = sync_lo_s + {2'b00, Sync};
        total_s     = sync_hi_s + {2'b00, Back};
        count_ext_s = {2'b00, count_q};
        Wrap        = Advance && (count_ext_s == (total_s - (W+2)'(1)));
        Error       = (Active == {W{1'b0}}) || (Sync == {W{1'b0}}) ||
                      (total_s > LIMIT);
    end

    // Next position and the flags that belong to it
    always_comb begin
        if (Wrap) begin
            count_d = {W{1'b0}};
        end else if (Advance) begin
            count_d = count_q + W'(1);
        end else begin
            count_d = count_q;
        end
        next_ext_s = {2'b00, count_d};
        sync_d = sync_level((next_ext_s >= sync_lo_s) && (next_ext_s < sync_hi_s), Pol);
        act_d  = (next_ext_s < {2'b00, Active});
    end

    // Position and output registers; clear parks at position 0, which is
    // inside the active segment of every legal configuration
    always_ff @(posedge CLK) begin
        if (RESET) begin
            count_q <= {W{1'b0}};
            sync_q  <= sync_level(1'b0, Pol);
            act_q   <= 1'b1;
        end else begin
            count_q <= count_d;
            sync_q  <= sync_d;
            act_q   <= act_d;
        end
    end

    assign Count    = count_q;
    assign SyncOut  = sync_q;
    assign InActive = act_q;

endmodule

// File: rtl/video_sync_timer.sv
// -----------------------------------------------------------------------------
// video_sync_timer
// Combined horizontal/vertical video timing generator with runtime timing
// inputs that are shadowed at frame boundaries.
// Ports:
//   CLK, RESET              system clock, synchronous active-high reset
//   Enable                  1 = run, 0 = freeze everything (pulses 0)
//   PixelDiv                one pixel tick every PixelDiv+1 clocks
//   HActive..HBack          horizontal segment lengths (pixels)
//   VActive..VBack          vertical segment lengths (lines)
//   HSyncPol, VSyncPol      1 = sync pulse high, 0 = sync pulse low
//   PixelTick               one-clock pixel strobe
//   hsync, vsync            registered sync outputs
//   xposition, yposition    current pixel column / line
//   ActiveVideo             inside the active picture area
//   LineEnd, FrameEnd       strobes on the last pixel of a line / frame
//   ConfigError             shadowed configuration is illegal
// -----------------------------------------------------------------------------
module video_sync_timer
    import video_sync_timer_pkg::*;
#(
    parameter int XBITS   = 10,
    parameter int YBITS   = 10,
    parameter int DIVBITS = 2
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               Enable,
    input  logic [DIVBITS-1:0] PixelDiv,
    input  logic [XBITS-1:0]   HActive,
    input  logic [XBITS-1:0]   HFront,
    input  logic [XBITS-1:0]   HSync,
    input  logic [XBITS-1:0]   HBack,
    input  logic [YBITS-1:0]   VActive,
    input  logic [YBITS-1:0]   VFront,
    input  logic [YBITS-1:0]   VSync,
    input  logic [YBITS-1:0]   VBack,
    input  logic               HSyncPol,
    input  logic               VSyncPol,
    output logic               PixelTick,
    output logic               hsync,
    output logic               vsync,
    output logic [XBITS-1:0]   xposition,
    output logic [YBITS-1:0]   yposition,
    output logic               ActiveVideo,
    output logic               LineEnd,
    output logic               FrameEnd,
    output logic               ConfigError
);

    logic [DIVBITS-1:0] div_q, div_d, pdiv_q, pdiv_d;
    logic [XBITS-1:0]   hact_q, hact_d, hfr_q, hfr_d, hsy_q, hsy_d, hbk_q, hbk_d;
    logic [YBITS-1:0]   vact_q, vact_d, vfr_q, vfr_d, vsy_q, vsy_d, vbk_q, vbk_d;
    logic               hpol_q, hpol_d, vpol_q, vpol_d;
    logic               load_s, cfg_err_s, h_err_s, v_err_s, tick_s;
    logic               h_wrap_s, v_wrap_s, axis_rst_s, h_act_s, v_act_s;

    assign cfg_err_s  = h_err_s | v_err_s;
    // An illegal configuration parks both axes exactly like a reset does
    assign axis_rst_s = RESET | cfg_err_s;

    // Pixel strobe: only while running a legal configuration
    always_comb begin
        if (!RESET && Enable && !cfg_err_s) begin
            tick_s = (div_q == pdiv_q);
        end else begin
            tick_s = 1'b0;
        end
    end

    // Divider next state: wraps on the tick, holds when disabled
    always_comb begin
        if (cfg_err_s || tick_s) begin
            div_d = {DIVBITS{1'b0}};
        end else if (Enable) begin
            div_d = div_q + DIVBITS'(1);
        end else begin
            div_d = div_q;
        end
    end

    // Shadow next state: reload at frame end, and every cycle while illegal
    always_comb begin
        load_s = RESET || (Enable && (cfg_err_s || v_wrap_s));
        if (load_s) begin
            pdiv_d = PixelDiv;
            hact_d = HActive;  hfr_d = HFront;  hsy_d = HSync;  hbk_d = HBack;
            vact_d = VActive;  vfr_d = VFront;  vsy_d = VSync;  vbk_d = VBack;
            hpol_d = HSyncPol; vpol_d = VSyncPol;
        end else begin
            pdiv_d = pdiv_q;
            hact_d = hact_q;   hfr_d = hfr_q;   hsy_d = hsy_q;   hbk_d = hbk_q;
            vact_d = vact_q;   vfr_d = vfr_q;   vsy_d = vsy_q;   vbk_d = vbk_q;
            hpol_d = hpol_q;   vpol_d = vpol_q;
        end
    end

    // Divider and shadow registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            div_q  <= {DIVBITS{1'b0}};
            pdiv_q <= PixelDiv;
            hact_q <= HActive;  hfr_q <= HFront;  hsy_q <= HSync;  hbk_q <= HBack;
            vact_q <= VActive;  vfr_q <= VFront;  vsy_q <= VSync;  vbk_q <= VBack;
            hpol_q <= HSyncPol; vpol_q <= VSyncPol;
        end else begin
            div_q  <= div_d;
            pdiv_q <= pdiv_d;
            hact_q <= hact_d;   hfr_q <= hfr_d;   hsy_q <= hsy_d;   hbk_q <= hbk_d;
            vact_q <= vact_d;   vfr_q <= vfr_d;   vsy_q <= vsy_d;   vbk_q <= vbk_d;
            hpol_q <= hpol_d;   vpol_q <= vpol_d;
        end
    end

    // Polarity goes in as the next shadow value so a polarity change at a
    // frame boundary reaches the registered sync pin on the first pixel.
    sync_axis_counter #(.W(XBITS)) u_h_axis (
        .CLK      (CLK),
        .RESET    (axis_rst_s),
        .Advance  (tick_s),
        .Active   (hact_q),
        .Front    (hfr_q),
        .Sync     (hsy_q),
        .Back     (hbk_q),
        .Pol      (hpol_d),
        .Count    (xposition),
        .Wrap     (h_wrap_s),
        .SyncOut  (hsync),
        .InActive (h_act_s),
        .Error    (h_err_s)
    );

    sync_axis_counter #(.W(YBITS)) u_v_axis (
        .CLK      (CLK),
        .RESET    (axis_rst_s),
        .Advance  (h_wrap_s),
        .Active   (vact_q),
        .Front    (vfr_q),
        .Sync     (vsy_q),
        .Back     (vbk_q),
        .Pol      (vpol_d),
        .Count    (yposition),
        .Wrap     (v_wrap_s),
        .SyncOut  (vsync),
        .InActive (v_act_s),
        .Error    (v_err_s)
    );

    assign PixelTick   = tick_s;
    assign LineEnd     = h_wrap_s;
    assign FrameEnd    = v_wrap_s;
    assign ConfigError = cfg_err_s;
    assign ActiveVideo = h_act_s & v_act_s & ~cfg_err_s;

endmodule

// File: tb/tb_video_sync_timer.sv
// -----------------------------------------------------------------------------
// tb_video_sync_timer
// Scoreboard bench: a reference model tracks the frame as a linear pixel
// index plus a divider phase and a shadow copy of the configuration, pushes
// the expected outputs for every clock into a queue, and a monitor on the
// falling edge pops and compares them with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_video_sync_timer;

    typedef struct packed {
        logic       tick, le, fe, hs, vs, av, ce;
        logic [9:0] x, y;
    } obs_t;

    logic       CLK = 1'b0;
    logic       RESET, Enable, HSyncPol, VSyncPol;
    logic [1:0] PixelDiv;
    logic [9:0] HActive, HFront, HSync, HBack, VActive, VFront, VSync, VBack;
    logic       PixelTick, hsync, vsync, ActiveVideo, LineEnd, FrameEnd, ConfigError;
    logic [9:0] xposition, yposition;

    int checks = 0;
    int passed = 0;

    video_sync_timer #(.XBITS(10), .YBITS(10), .DIVBITS(2)) dut (
        .CLK(CLK), .RESET(RESET), .Enable(Enable), .PixelDiv(PixelDiv),
        .HActive(HActive), .HFront(HFront), .HSync(HSync), .HBack(HBack),
        .VActive(VActive), .VFront(VFront), .VSync(VSync), .VBack(VBack),
        .HSyncPol(HSyncPol), .VSyncPol(VSyncPol),
        .PixelTick(PixelTick), .hsync(hsync), .vsync(vsync),
        .xposition(xposition), .yposition(yposition), .ActiveVideo(ActiveVideo),
        .LineEnd(LineEnd), .FrameEnd(FrameEnd), .ConfigError(ConfigError)
    );

    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    int s_ha, s_hf, s_hs, s_hb, s_va, s_vf, s_vs, s_vb, s_pd;
    bit s_hp, s_vp;
    int p = 0;   // pixel index inside the frame: y*HT + x
    int d = 0;   // clocks since the last pixel tick
    obs_t exp_q[$];

    function automatic int ht_f(); return s_ha + s_hf + s_hs + s_hb; endfunction
    function automatic int vt_f(); return s_va + s_vf + s_vs + s_vb; endfunction

    function automatic bit bad_f();
        return (s_ha == 0) || (s_hs == 0) || (s_va == 0) || (s_vs == 0) ||
               (ht_f() > 1024) || (vt_f() > 1024);
    endfunction

    task automatic load_shadow();
        s_ha = int'(HActive); s_hf = int'(HFront); s_hs = int'(HSync); s_hb = int'(HBack);
        s_va = int'(VActive); s_vf = int'(VFront); s_vs = int'(VSync); s_vb = int'(VBack);
        s_pd = int'(PixelDiv); s_hp = HSyncPol; s_vp = VSyncPol;
    endtask

    function automatic bit tick_f();
        return (RESET == 1'b0) && (Enable == 1'b1) && !bad_f() && (d == s_pd);
    endfunction

    function automatic obs_t expect_f();
        obs_t e;
        int   x, y, ht, vt;
        bit   err, in_h, in_v;
        ht  = ht_f();
        vt  = vt_f();
        err = bad_f();
        if (err) begin
            x = 0; y = 0;
        end else begin
            x = p % ht; y = p / ht;
        end
        in_h = !err && (x >= s_ha + s_hf) && (x < s_ha + s_hf + s_hs);
        in_v = !err && (y >= s_va + s_vf) && (y < s_va + s_vf + s_vs);
        e.tick = tick_f();
        e.le   = e.tick && (x == ht - 1);
        e.fe   = e.le && (y == vt - 1);
        e.hs   = in_h ? s_hp : !s_hp;
        e.vs   = in_v ? s_vp : !s_vp;
        e.av   = !err && (x < s_ha) && (y < s_va);
        e.ce   = err;
        e.x    = 10'(x);
        e.y    = 10'(y);
        return e;
    endfunction

    // Advance the model on each edge, then predict the cycle that follows
    always @(posedge CLK) begin
        bit t, err;
        int frame_len;
        t = tick_f();
        err = bad_f();
        frame_len = ht_f() * vt_f();
        if (RESET) begin
            load_shadow(); p = 0; d = 0;
        end else if (Enable) begin
            if (err) begin
                load_shadow(); p = 0; d = 0;
            end else if (t) begin
                d = 0;
                if (p == frame_len - 1) begin
                    p = 0; load_shadow();
                end else begin
                    p = p + 1;
                end
            end else begin
                d = d + 1;
            end
        end
        #2;
        exp_q.push_back(expect_f());
    end

    // ---------------- monitor ----------------
    always @(negedge CLK) begin
        obs_t a, e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a.tick = PixelTick; a.le = LineEnd; a.fe = FrameEnd;
            a.hs = hsync; a.vs = vsync; a.av = ActiveVideo; a.ce = ConfigError;
            a.x = xposition; a.y = yposition;
            checks++;
            if (a !== e) begin
                $display("FAIL outputs t=%0t got x=%0d y=%0d tk=%b le=%b fe=%b hs=%b vs=%b av=%b ce=%b need x=%0d y=%0d tk=%b le=%b fe=%b hs=%b vs=%b av=%b ce=%b",
                         $time, a.x, a.y, a.tick, a.le, a.fe, a.hs, a.vs, a.av, a.ce,
                         e.x, e.y, e.tick, e.le, e.fe, e.hs, e.vs, e.av, e.ce);
            end else begin
                passed++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_cfg(input int ha, hf, hs, hb, va, vf, vs, vb, pd,
                           input bit hp, vp);
        HActive = 10'(ha); HFront = 10'(hf); HSync = 10'(hs); HBack = 10'(hb);
        VActive = 10'(va); VFront = 10'(vf); VSync = 10'(vs); VBack = 10'(vb);
        PixelDiv = 2'(pd); HSyncPol = hp; VSyncPol = vp;
    endtask

    task automatic rand_cfg();
        int ha, hs, va, vs;
        ha = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
        hs = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 3));
        va = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4));
        vs = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 2));
        set_cfg(ha, int'($urandom_range(0, 3)), hs, int'($urandom_range(0, 3)),
                va, int'($urandom_range(0, 2)), vs, int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
    endtask

    task automatic reset_pulse(input int n);
        RESET = 1'b1;
        repeat (n) cyc();
        RESET = 1'b0;
    endtask

    initial begin
        bit found;
        RESET  = 1'b1;
        Enable = 1'b1;
        set_cfg(4, 1, 2, 1, 3, 1, 1, 1, 0, 1'b0, 1'b0);
        repeat (3) cyc();
        RESET = 1'b0;
        // basic line/frame timing
        repeat (150) cyc();
        // divider, applied at the next frame boundary
        PixelDiv = 2'd2;
        repeat (350) cyc();
        // positive hsync
        HSyncPol = 1'b1;
        repeat (200) cyc();
        PixelDiv = 2'd0;
        repeat (60) cyc();
        // mid-frame width change
        HActive = 10'd6;
        repeat (200) cyc();
        // illegal configuration, then recovery
        HSync = 10'd0;
        repeat (80) cyc();
        HSync = 10'd2;
        repeat (100) cyc();

        // reset at x=3, y=2, then freeze
        set_cfg(4, 1, 2, 1, 3, 1, 1, 1, 0, 1'b0, 1'b0);
        reset_pulse(2);
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            if (!bad_f() && (p == 2 * ht_f() + 3)) found = 1'b1;
            else cyc();
        end
        if (!found) begin
            checks++;
            $display("FAIL wait_x3_y2 reached=0 required=1");
        end
        reset_pulse(1);
        repeat (5) cyc();
        Enable = 1'b0;
        repeat (10) cyc();
        Enable = 1'b1;
        repeat (30) cyc();

        // randomized configurations, enables and resets
        for (int it = 0; it < 10; it++) begin
            rand_cfg();
            reset_pulse(1);
            for (int c = 0; c < 400; c++) begin
                Enable = ($urandom_range(0, 7) != 0);
                RESET  = ($urandom_range(0, 299) == 0);
                if (c == 200) rand_cfg();
                cyc();
            end
            RESET  = 1'b0;
            Enable = 1'b1;
        end

        // width limit: HT = 1024 is legal, 1025 is not
        set_cfg(1000, 10, 10, 4, 1, 0, 1, 0, 0, 1'b1, 1'b1);
        reset_pulse(2);
        repeat (2100) cyc();
        HBack = 10'd5;
        repeat (2100) cyc();
        // height limit: VT = 1025 is illegal
        set_cfg(4, 1, 2, 1, 1000, 10, 10, 5, 0, 1'b0, 1'b0);
        reset_pulse(2);
        repeat (10) cyc();

        repeat (2) cyc();
        @(negedge CLK);
        #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
